gshare_pht: RTL and testbench

- Direction predictor downstream of the fetch-stage BTB.
- Combines the BTB hit/target outputs with a gshare pattern history table of 2-bit saturating counters to produce the fetch-stage taken prediction and next-PC target.
- Carries prediction state down to execute, trains counters and global history there, and emits PHTincrement_o back to the BTB as its write condition.

---
 rtl/gshare_pht_if.sv | 24 ++
 rtl/gshare_pht.sv | 86 ++++++++
 tb/tb_gshare_pht.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_pht_if.sv
// Fetch/execute-side signal bundle between the pipeline (master) and the
// gshare direction predictor (slave).
interface gshare_pht_if;
   logic [31:0] pc_i;
   logic [31:0] btb_target_i;
   logic        btb_jumphit_i;
   logic        btb_branchhit_i;
   logic        branch_e_i;
   logic        taken_e_i;
   logic        predict_taken_o;
   logic [31:0] predict_target_o;
   logic        mispredict_e_o;
   logic        PHTincrement_o;

   modport master (
      output pc_i, btb_target_i, btb_jumphit_i, btb_branchhit_i, branch_e_i, taken_e_i,
      input  predict_taken_o, predict_target_o, mispredict_e_o, PHTincrement_o
   );

   modport slave (
      input  pc_i, btb_target_i, btb_jumphit_i, btb_branchhit_i, branch_e_i, taken_e_i,
      output predict_taken_o, predict_target_o, mispredict_e_o, PHTincrement_o
   );
endinterface

// File: rtl/gshare_pht.sv
// Gshare direction predictor behind the BTB: fetch-stage prediction, f->d->e
// tracking of the prediction, and non-speculative training at execute.
module gshare_pht #(
   parameter int NUM_PHT_ENTRIES = 64,
   parameter int GHR_BITS        = 6
) (
   input  logic                clk,
   input  logic                reset_i,
   gshare_pht_if.slave         bus,
   input  logic                stall_i,
   input  logic                flush_i,
   output logic [GHR_BITS-1:0] ghr_o
);
   localparam int LOG2_PHT = $clog2(NUM_PHT_ENTRIES);

   typedef logic [LOG2_PHT-1:0] idx_t;
   typedef struct packed {
      idx_t idx;
      logic pred;
   } trk_t;

   logic [1:0]          pht [NUM_PHT_ENTRIES];
   logic [GHR_BITS-1:0] ghr;
   logic [GHR_BITS:0]   ghr_shift;
   logic [2:1]          vld_pipe;  // [1] decode, [2] execute; fetch is always valid
   trk_t                trk_f, trk_d, trk_e;
   idx_t                idx_f;
   logic [1:0]          ctr_f, ctr_e, ctr_nxt;
   logic                update_e;

   // ---------------- fetch ----------------
   assign idx_f = bus.pc_i[LOG2_PHT+1:2] ^ idx_t'(ghr);
   assign ctr_f = pht[idx_f];

   assign bus.predict_taken_o  = bus.btb_jumphit_i | (bus.btb_branchhit_i & ctr_f[1]);
   assign bus.predict_target_o = bus.predict_taken_o ? bus.btb_target_i : bus.pc_i + 32'd4;

   assign trk_f.idx  = idx_f;
   assign trk_f.pred = bus.btb_branchhit_i & ctr_f[1];

   // ---------------- tracking pipeline ----------------
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         vld_pipe <= '0;
         trk_d    <= '0;
         trk_e    <= '0;
      end else if (flush_i) begin
         vld_pipe <= '0;
      end else if (!stall_i) begin
         vld_pipe <= {vld_pipe[1], 1'b1};
         trk_d    <= trk_f;
         trk_e    <= trk_d;
      end
   end

   // ---------------- execute ----------------
   assign update_e           = bus.branch_e_i & vld_pipe[2] & !stall_i;
   assign bus.mispredict_e_o = bus.branch_e_i & vld_pipe[2] & (trk_e.pred ^ bus.taken_e_i);
   // Level held through stalls so the BTB write condition stays stable.
   assign bus.PHTincrement_o = bus.branch_e_i & vld_pipe[2] & bus.taken_e_i;

   assign ctr_e     = pht[trk_e.idx];
   assign ghr_shift = {ghr, bus.taken_e_i};

   always_comb begin
      ctr_nxt = ctr_e;
      if (bus.taken_e_i) begin
         if (ctr_e != 2'b11) ctr_nxt = ctr_e + 2'b01;
      end else begin
         if (ctr_e != 2'b00) ctr_nxt = ctr_e - 2'b01;
      end
   end

   // Writes land at the edge, so a same-cycle fetch read of this entry sees the old value.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_PHT_ENTRIES; i++) pht[i] <= 2'b01;
         ghr <= '0;
      end else if (update_e) begin
         pht[trk_e.idx] <= ctr_nxt;
         ghr            <= ghr_shift[GHR_BITS-1:0];
      end
   end

   assign ghr_o = ghr;
endmodule

// File: tb/tb_gshare_pht.sv
// Self-checking bench for gshare_pht: directed vectors, directed multi-cycle
// corner sequences, and randomized traffic against an abstract predictor model.
module tb_gshare_pht;
   localparam int N = 64;
   localparam int G = 6;

   logic         clk = 1'b0;
   logic         reset_i = 1'b1;
   logic         stall_i = 1'b0;
   logic         flush_i = 1'b0;
   logic [G-1:0] ghr_o;

   gshare_pht_if bus ();

   gshare_pht #(.NUM_PHT_ENTRIES(N), .GHR_BITS(G)) dut (
      .clk     (clk),
      .reset_i (reset_i),
      .bus     (bus.slave),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .ghr_o   (ghr_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Abstract model: counters as integers 0..3, history as an integer,
   // and the two in-flight prediction records downstream of fetch.
   int m_cnt [N];
   int m_ghr;
   bit md_v, me_v;
   int md_idx, me_idx;
   bit md_p, me_p;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        jh;
      logic        bh;
      logic        exp_taken;
      logic [31:0] exp_target;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_cnt[i] = 1;
      m_ghr = 0;
      md_v = 0; me_v = 0; md_idx = 0; me_idx = 0; md_p = 0; me_p = 0;
   endtask

   function automatic int m_index(input logic [31:0] pc);
      return ((pc >> 2) % N) ^ m_ghr;
   endfunction

   task automatic drv(input logic [31:0] pc, input logic [31:0] tgt, input logic jh,
                      input logic bh, input logic st, input logic fl,
                      input logic be, input logic te);
      bus.pc_i = pc; bus.btb_target_i = tgt;
      bus.btb_jumphit_i = jh; bus.btb_branchhit_i = bh;
      stall_i = st; flush_i = fl;
      bus.branch_e_i = be; bus.taken_e_i = te;
   endtask

   task automatic bubble(input logic st, input logic fl, input logic be, input logic te);
      drv(32'h0000_1000, 32'h0, 1'b0, 1'b0, st, fl, be, te);
   endtask

   // Checks every output against the model, then advances one clock.
   task automatic step();
      int idx; bit hi; bit t; bit upd;
      #1;
      idx = m_index(bus.pc_i);
      hi  = (m_cnt[idx] >= 2);
      t   = bus.btb_jumphit_i | (bus.btb_branchhit_i & hi);
      chk("predict_taken", {31'b0, bus.predict_taken_o}, {31'b0, t});
      chk("predict_target", bus.predict_target_o, t ? bus.btb_target_i : bus.pc_i + 32'd4);
      chk("mispredict", {31'b0, bus.mispredict_e_o},
          {31'b0, bus.branch_e_i & me_v & (me_p != bus.taken_e_i)});
      chk("pht_increment", {31'b0, bus.PHTincrement_o},
          {31'b0, bus.branch_e_i & me_v & bus.taken_e_i});
      chk("ghr", {26'b0, ghr_o}, m_ghr);
      @(posedge clk);
      upd = bus.branch_e_i & me_v & !stall_i;
      if (upd) begin
         if (bus.taken_e_i) m_cnt[me_idx] = (m_cnt[me_idx] == 3) ? 3 : m_cnt[me_idx] + 1;
         else               m_cnt[me_idx] = (m_cnt[me_idx] == 0) ? 0 : m_cnt[me_idx] - 1;
         m_ghr = ((m_ghr * 2) + (bus.taken_e_i ? 1 : 0)) % (1 << G);
      end
      if (flush_i) begin
         md_v = 0; me_v = 0;
      end else if (!stall_i) begin
         me_v = md_v; me_idx = md_idx; me_p = md_p;
         md_v = 1; md_idx = idx; md_p = bus.btb_branchhit_i & hi;
      end
      @(negedge clk);
   endtask

   // Asynchronous reset asserted mid-cycle, held across one rising edge.
   task automatic pulse_reset();
      #2 reset_i = 1'b1;
      model_reset();
      #1 chk("reset_async_ghr", {26'b0, ghr_o}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset_i = 1'b0;
   endtask

   // One branch at PHT slot `slot`, resolved two cycles later with outcome `te`.
   task automatic branch_resolve(input int slot, input logic te, input logic exp_pred,
                                 input logic exp_mis, input string tag);
      logic [31:0] pc;
      pc = 32'((slot ^ m_ghr) << 2);
      drv(pc, 32'h0000_3000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk({tag, "_pred"}, {31'b0, bus.predict_taken_o}, {31'b0, exp_pred});
      step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0);
      step();
      bubble(1'b0, 1'b0, 1'b1, te);
      #1 chk({tag, "_mis"}, {31'b0, bus.mispredict_e_o}, {31'b0, exp_mis});
      chk({tag, "_inc"}, {31'b0, bus.PHTincrement_o}, {31'b0, te});
      step();
   endtask

   initial begin
      logic [G-1:0] saved;
      logic [31:0]  pc;
      bit tk [3]  = '{1'b0, 1'b1, 1'b1};
      bit ntp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

      vecs[0] = '{32'h0000_0100, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 32'h0000_0104};
      vecs[1] = '{32'h0000_0100, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 32'h0000_2000};
      vecs[2] = '{32'h0000_0040, 32'h0000_2000, 1'b0, 1'b1, 1'b0, 32'h0000_0044};
      vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0800, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
      vecs[4] = '{32'h0000_0040, 32'hDEAD_BEE0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEE0};
      vecs[5] = '{32'h1234_5678, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 32'h0000_0010};

      model_reset();
      drv(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      #1 chk("reset_held_target", bus.predict_target_o, 32'h104);
      @(negedge clk);
      reset_i = 1'b0;

      // Post-reset state; e-stage inputs active but nothing valid downstream.
      #1;
      chk("reset_taken",  {31'b0, bus.predict_taken_o}, 32'd0);
      chk("reset_target", bus.predict_target_o, 32'h104);
      chk("reset_ghr",    {26'b0, ghr_o}, 32'd0);
      chk("reset_mis",    {31'b0, bus.mispredict_e_o}, 32'd0);
      chk("reset_inc",    {31'b0, bus.PHTincrement_o}, 32'd0);
      step();

      foreach (vecs[i]) begin
         drv(vecs[i].pc, vecs[i].tgt, vecs[i].jh, vecs[i].bh, 1'b0, 1'b0, 1'b0, 1'b0);
         #1;
         chk($sformatf("vec%0d_taken", i), {31'b0, bus.predict_taken_o}, {31'b0, vecs[i].exp_taken});
         chk($sformatf("vec%0d_target", i), bus.predict_target_o, vecs[i].exp_target);
         step();
      end
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();

      // Slot 16 trained taken three times: 01 -> 10 -> 11 -> 11.
      foreach (tk[k]) branch_resolve(16, 1'b1, tk[k], !tk[k], $sformatf("taken%0d", k));
      chk("ghr_after_taken", {26'b0, ghr_o}, 32'b000111);
      // Then four not-taken: 11 -> 10 -> 01 -> 00 -> 00.
      foreach (ntp[k]) branch_resolve(16, 1'b0, ntp[k], ntp[k], $sformatf("ntaken%0d", k));
      chk("ghr_after_ntaken", {26'b0, ghr_o}, 32'b110000);

      // Stall with a taken branch sitting in execute.
      pc = 32'((5 ^ m_ghr) << 2);
      drv(pc, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();
      saved = ghr_o;
      for (int s = 0; s < 3; s++) begin
         bubble(1'b1, 1'b0, 1'b1, 1'b1);
         #1 chk("stall_inc_level", {31'b0, bus.PHTincrement_o}, 32'd1);
         chk("stall_ghr_hold", {26'b0, ghr_o}, {26'b0, saved});
         step();
      end
      bubble(1'b0, 1'b0, 1'b1, 1'b1); step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("stall_one_update", {26'b0, ghr_o}, {26'b0, saved[G-2:0], 1'b1});
      step();
      pc = 32'((5 ^ m_ghr) << 2);
      drv(pc, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("stall_ctr_10", {31'b0, bus.predict_taken_o}, 32'd1);
      step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();

      // Flush kills the branch on its way to execute.
      pc = 32'((9 ^ m_ghr) << 2);
      drv(pc, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
      bubble(1'b0, 1'b1, 1'b0, 1'b0); step();
      saved = ghr_o;
      bubble(1'b0, 1'b0, 1'b1, 1'b1);
      #1 chk("flush_mis", {31'b0, bus.mispredict_e_o}, 32'd0);
      chk("flush_inc", {31'b0, bus.PHTincrement_o}, 32'd0);
      step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("flush_no_train", {26'b0, ghr_o}, {26'b0, saved});
      step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();

      // Fetch and execute hit the same slot in the same cycle.
      pc = 32'((12 ^ m_ghr) << 2);
      drv(pc, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();
      drv(pc, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      #1 chk("collide_old_value", {31'b0, bus.predict_taken_o}, 32'd0);
      step();
      pc = 32'((12 ^ m_ghr) << 2);
      drv(pc, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("collide_new_value", {31'b0, bus.predict_taken_o}, 32'd1);
      step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();

      // Reset lands while a taken branch is resolving: no partial update.
      pc = 32'((20 ^ m_ghr) << 2);
      drv(pc, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();
      bubble(1'b0, 1'b0, 1'b1, 1'b1);
      pulse_reset();
      drv(32'(20 << 2), 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      #1 chk("midreset_ctr", {31'b0, bus.predict_taken_o}, 32'd0);
      chk("midreset_mis", {31'b0, bus.mispredict_e_o}, 32'd0);
      step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();
      bubble(1'b0, 1'b0, 1'b0, 1'b0); step();
      // Slot 16 was 00 before reset; one taken resolve from 01 must flip it.
      branch_resolve(16, 1'b1, 1'b0, 1'b1, "postreset");
      chk("postreset_ghr", {26'b0, ghr_o}, 32'd1);
      drv(32'h44, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("postreset_ctr10", {31'b0, bus.predict_taken_o}, 32'd1);
      step();

      // Randomized traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63) << 2) : $urandom;
         drv(rpc, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
             $urandom_range(0, 1), $urandom_range(0, 1));
         if ($urandom_range(0, 299) == 0) pulse_reset();
         else step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
